// File: rtl/hilo_muldiv.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle, shift-add multiply and restoring divide.
// Optional macro HILO_SIGNED_EN enables signed MULT/DIV; when undefined, op[0] is ignored and all ops are unsigned.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Handshake: start is taken only in IDLE with flush low; done is a one-cycle
  // pulse coinciding with busy falling. mthi/mtlo only act in IDLE.
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, mq_q, d_q, hi_q, lo_q;
  logic             is_div_q, zdiv_q, done_q, dbz_q;
  logic             accept, last, op_div;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, rem_sh;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] acc_n, mq_n, res_hi, res_lo;

  assign accept = (state_q == IDLE) && start && !flush;
  assign last   = (cnt_q == CW'(1));
  assign op_div = op[1];

`ifdef HILO_SIGNED_EN
  logic signed_op, a_neg, b_neg, neg_res_q, neg_rem_q;
  logic [2*WIDTH-1:0] prod_fix;
  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
`else
  logic unused_op0;
  assign unused_op0 = op[0];
  assign a_mag      = a;
  assign b_mag      = b;
`endif

  // One iteration step: multiplier bits shift out of mq, quotient bits shift into mq.
  always_comb begin
    sum    = {1'b0, acc_q} + (mq_q[0] ? {1'b0, d_q} : '0);
    rem_sh = {acc_q, mq_q[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, d_q};
    ge     = ~diff[WIDTH+1];
    if (is_div_q) begin
      acc_n = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      mq_n  = {mq_q[WIDTH-2:0], ge};
    end else begin
      acc_n = sum[WIDTH:1];
      mq_n  = {sum[0], mq_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    res_hi = acc_n;
    res_lo = mq_n;
`ifdef HILO_SIGNED_EN
    prod_fix = -{acc_n, mq_n};
    if (!is_div_q) begin
      if (neg_res_q) {res_hi, res_lo} = prod_fix;
    end else begin
      if (neg_res_q) res_lo = -mq_n;
      if (neg_rem_q) res_hi = -acc_n;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (flush || last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      d_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      zdiv_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
`ifdef HILO_SIGNED_EN
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      if (state_q == IDLE) begin
        if (accept) begin
          is_div_q <= op_div;
          zdiv_q   <= op_div && (b == '0);
          d_q      <= op_div ? b_mag : a_mag;
          mq_q     <= op_div ? a_mag : b_mag;
          // A zero divisor parks the raw dividend in acc and finishes next edge.
          acc_q    <= (op_div && (b == '0)) ? a : '0;
          cnt_q    <= (op_div && (b == '0)) ? CW'(1) : CW'(WIDTH);
`ifdef HILO_SIGNED_EN
          neg_res_q <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
`endif
        end else begin
          if (mthi) hi_q <= wdata;
          if (mtlo) lo_q <= wdata;
        end
      end else if (flush) begin
        cnt_q <= '0;
      end else if (zdiv_q) begin
        hi_q   <= acc_q;
        lo_q   <= '1;
        done_q <= 1'b1;
        dbz_q  <= 1'b1;
        cnt_q  <= '0;
      end else begin
        acc_q <= acc_n;
        mq_q  <= mq_n;
        cnt_q <= cnt_q - CW'(1);
        if (last) begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv (WIDTH=32); signed expectations follow HILO_SIGNED_EN.
module tb_hilo_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, mthi, mtlo, flush;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic [W-1:0] hi, lo;
  logic         busy, done, div_by_zero, state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc;

  hilo_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .flush(flush),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    step();
    start = 1'b0;
  endtask

  // Counts edges after acceptance until done; bounded so a dead DUT still reaches the summary.
  task automatic wait_done(output int n);
    n = 0;
    while (n < 100) begin
      step();
      n++;
      if (done) break;
    end
    if (!done) n = 999;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    step(); step();
    reset = 1'b0;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);

    // MULTU all-ones squared
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_busy", busy, 1);
    wait_done(cyc);
    check("multu_lat", cyc, 32);
    check("multu_busy_done", busy, 0);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);
    check("multu_dbz", div_by_zero, 0);
    step();
    check("multu_done_1cyc", done, 0);

    // MULT -3 * 5
    start_op(2'b00, 32'hFFFF_FFFD, 32'd5);
    wait_done(cyc);
    check("mult_lat", cyc, 32);
`ifdef HILO_SIGNED_EN
    check("mult_hi", hi, 32'hFFFF_FFFF);
`else
    check("mult_hi", hi, 32'h0000_0004);
`endif
    check("mult_lo", lo, 32'hFFFF_FFF1);

    // DIV -7 / 2
    start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
`ifdef HILO_SIGNED_EN
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
`else
    check("div_lo", lo, 32'h7FFF_FFFC);
    check("div_hi", hi, 32'h0000_0001);
`endif

    // DIVU by zero
    start_op(2'b11, 32'h0000_1234, 32'd0);
    wait_done(cyc);
    check("dbz_lat", cyc, 1);
    check("dbz_flag", div_by_zero, 1);
    check("dbz_hi", hi, 32'h0000_1234);
    check("dbz_lo", lo, 32'hFFFF_FFFF);
    step();
    check("dbz_flag_drop", div_by_zero, 0);

    // DIVU 100 / 7
    start_op(2'b11, 32'd100, 32'd7);
    wait_done(cyc);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // DIV most-negative / -1
    start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
`ifdef HILO_SIGNED_EN
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'h0000_0000);
`else
    check("ovf_lo", lo, 32'h0000_0000);
    check("ovf_hi", hi, 32'h8000_0000);
`endif

    // mthi/mtlo preload, then MULTU flushed 10 cycles after start
    mthi = 1'b1; wdata = 32'h55;
    step();
    mthi = 1'b0; mtlo = 1'b1;
    step();
    mtlo = 1'b0;
    check("mt_hi", hi, 32'h55);
    check("mt_lo", lo, 32'h55);
    start_op(2'b01, 32'd3, 32'd4);
    for (int i = 0; i < 9; i++) step();
    check("flush_busy_pre", busy, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    for (int i = 0; i < 30; i++) begin
      step();
      if (done) check("flush_no_done", done, 0);
    end
    check("flush_hi", hi, 32'h55);
    check("flush_lo", lo, 32'h55);

    // flush beats start in IDLE
    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd9; b = 32'd9;
    step();
    start = 1'b0; flush = 1'b0;
    check("flush_prio_busy", busy, 0);

    // start + mthi in IDLE: write dropped
    start = 1'b1; mthi = 1'b1; wdata = 32'hAA; op = 2'b01; a = 32'd2; b = 32'd3;
    step();
    start = 1'b0; mthi = 1'b0;
    check("st_mt_busy", busy, 1);
    wait_done(cyc);
    check("st_mt_hi", hi, 32'd0);
    check("st_mt_lo", lo, 32'd6);

    // second start and mtlo while busy are ignored
    start_op(2'b01, 32'd6, 32'd7);
    step(); step();
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd100;
    mtlo = 1'b1; wdata = 32'h77;
    step();
    start = 1'b0; mtlo = 1'b0;
    check("busy_mtlo_ign", lo, 32'd6);
    wait_done(cyc);
    check("restart_lat", cyc, 29);
    check("restart_hi", hi, 32'd0);
    check("restart_lo", lo, 32'd42);

    // reset mid-DIV, then a normal DIVU
    start_op(2'b11, 32'd1000, 32'd3);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_dbz", div_by_zero, 0);
    start_op(2'b11, 32'd1000, 32'd3);
    wait_done(cyc);
    check("post_rst_lat", cyc, 32);
    check("post_rst_lo", lo, 32'd333);
    check("post_rst_hi", hi, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width; legal values even and >= 4.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports a, b  input  WIDTH each  source operands; a is the dividend and b the divisor.
REQ-007 SHALL have ports mthi, mtlo  input  1 each  write wdata into HI/LO.
REQ-008 SHALL have port wdata  input  WIDTH  data for mthi/mtlo.
REQ-009 SHALL have port flush  input  1  abort the operation in flight.
REQ-010 SHALL have ports hi, lo  output  WIDTH each  architectural HI/LO registers.
REQ-011 SHALL have port busy  output  1  high while in RUN; used by the hazard unit to stall.
REQ-012 SHALL have ports done, div_by_zero  output  1 each  one-cycle completion pulse; zero-divisor flag.

Function
REQ-013 SHALL implement FSM states IDLE and RUN; IDLE->RUN on accepted start; RUN->IDLE on count expiry or flush.
REQ-014 SHALL accept start only in IDLE with flush low; the operation is accepted at edge k, busy=1 from edge k through edge k+WIDTH.
REQ-015 SHALL iterate one bit per cycle: shift-add multiply and restoring divide, WIDTH iterations, counter width clog2(WIDTH)+1.
REQ-016 SHALL load hi/lo and pulse done=1 for exactly one cycle at edge k+WIDTH; busy=0 in that same cycle.
REQ-017 SHALL produce a 2*WIDTH-bit product for MULT/MULTU: HI=upper half, LO=lower half.
REQ-018 SHALL produce LO=quotient and HI=remainder for DIV/DIVU.
REQ-019 SHALL, for signed ops, operate on magnitudes: product or quotient negated when operand signs differ; remainder takes the dividend's sign.
REQ-020 SHALL return LO=0x80..0 and HI=0 for signed most-negative / -1.
REQ-021 SHALL, for DIV/DIVU with b==0, skip iteration: done and div_by_zero pulse at edge k+1, HI=a, LO=all ones.
REQ-022 SHALL ignore start while busy, with no effect on the operation in flight.
REQ-023 SHALL, on flush in RUN, return to IDLE at the next edge with hi/lo unchanged and no done pulse.
REQ-024 SHALL give flush priority over start when both are high in IDLE; start is dropped.
REQ-025 SHALL ignore mthi/mtlo while busy; in IDLE, writes take effect at the next edge.
REQ-026 SHALL, when start and mthi/mtlo are both accepted in IDLE, drop the write.
REQ-027 SHALL hold div_by_zero low except in its done cycle.

Reset
REQ-028 SHALL, on reset high at an edge, set state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0, including mid-operation.
REQ-029 SHALL give reset priority over flush, start and mthi/mtlo.

Configuration
REQ-030 SHALL honour macro HILO_SIGNED_EN.
- Defined: MULT/DIV signed per REQ-019/020.
- Undefined: op[0] ignored, all ops unsigned, no sign-correction logic synthesised.

Verification (WIDTH=32, HILO_SIGNED_EN defined)
REQ-031 SHALL cover MULTU 0xFFFFFFFF*0xFFFFFFFF -> done exactly 32 cycles after start, HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 SHALL cover MULT a=0xFFFFFFFD, b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; DIV a=0xFFFFFFF9, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-033 SHALL cover DIVU a=0x1234, b=0 -> done and div_by_zero 1 cycle after start, HI=0x1234, LO=0xFFFFFFFF.
REQ-034 SHALL cover HI=LO=0x55 preloaded via mthi/mtlo, then MULTU started and flush asserted 10 cycles later -> busy drops next edge, no done, HI=LO=0x55.
REQ-035 SHALL cover a second start issued while busy with different operands -> ignored, the first result is delivered on schedule.
REQ-036 SHALL cover reset asserted mid-DIV -> all outputs 0 at the next edge, and a following start behaves normally.
